// File: rtl/instr_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// instr_fetch_ctrl
//   Fetch sequencer for a 2-cycle-latency instruction memory (registered ROM
//   plus registered output). Owns the PC, drives the memory address, tracks
//   in-flight reads and buffers returning words (output register + 2-entry
//   skid) so decode can stall or redirect without losing or duplicating
//   instructions.
//
// Ports
//   clk               system clock, rising edge
//   reset             synchronous, active-low reset
//   i_Start           pulse: leave IDLE and begin fetching
//   i_Stop            pulse: stop issuing, drain, return to IDLE
//   i_Stall           consumer not accepting this cycle
//   i_Redirect        flush and refetch from i_Redirect_Addr
//   i_Redirect_Addr   redirect target
//   o_Mem_Address     address to instruction memory (the PC register)
//   i_Mem_Instruction memory read data, 2 cycles after address
//   o_Instruction     registered instruction to decode
//   o_PC              address of o_Instruction
//   o_Valid           o_Instruction/o_PC valid
//   o_Busy            state != IDLE
//
// Optional feature (macro IFETCH_STATS_EN):
//   o_Fetch_Count     accepted instructions, saturating 16 bit
//   o_Stall_Count     cycles with o_Valid && i_Stall, saturating 16 bit
// ----------------------------------------------------------------------------
module instr_fetch_ctrl #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 27,
    parameter int START_ADDR = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_Start,
    input  logic                  i_Stop,
    input  logic                  i_Stall,
    input  logic                  i_Redirect,
    input  logic [ADDR_WIDTH-1:0] i_Redirect_Addr,
    output logic [ADDR_WIDTH-1:0] o_Mem_Address,
    input  logic [DATA_WIDTH-1:0] i_Mem_Instruction,
    output logic [DATA_WIDTH-1:0] o_Instruction,
    output logic [ADDR_WIDTH-1:0] o_PC,
    output logic                  o_Valid,
    output logic                  o_Busy
`ifdef IFETCH_STATS_EN
    ,
    output logic [15:0]           o_Fetch_Count,
    output logic [15:0]           o_Stall_Count
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] pc;

    // In-flight tracker: stage 1 = address sampled by the ROM, stage 2 =
    // word present on i_Mem_Instruction this cycle.
    logic                  vld1, vld2;
    logic [ADDR_WIDTH-1:0] addr1, addr2;

    // Skid FIFO, entry 0 is the head.
    logic [1:0]            skid_cnt;
    logic [ADDR_WIDTH-1:0] skid_addr [2];
    logic [DATA_WIDTH-1:0] skid_data [2];

    logic       accept, arrive, out_load, pop, push, flush, issue, room;
    logic       skid_wr_idx;
    logic [2:0] occ, inflight;

    assign o_Mem_Address = pc;
    assign o_Busy        = (state != IDLE);

    always_comb begin
        accept   = o_Valid && !i_Stall;
        arrive   = vld2;
        out_load = !o_Valid || accept;
        pop      = out_load && (skid_cnt != 2'd0);
        // An arriving word bypasses the skid only when the output slot is
        // free and nothing older is queued; otherwise it queues behind.
        push     = arrive && !(out_load && (skid_cnt == 2'd0));
        // Write slot after this cycle's pop has shifted the queue.
        skid_wr_idx = (skid_cnt == 2'd2) || ((skid_cnt == 2'd1) && !pop);
        flush    = i_Redirect && (state != IDLE);
        occ      = {2'b0, o_Valid} + {1'b0, skid_cnt};
        inflight = {2'b0, vld1} + {2'b0, vld2};
        // Issue only if every word already owed, plus this one, has a slot.
        room     = (occ + inflight) < (3'd3 + {2'b0, accept});
        issue    = (state == RUN) && !i_Stop && !flush && room;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_Start) state_nxt = RUN;
            RUN:     if (i_Stop && !i_Redirect) state_nxt = DRAIN;
            DRAIN:   if (!vld1 && !vld2 && !o_Valid && (skid_cnt == 2'd0))
                         state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc            <= ADDR_WIDTH'(START_ADDR);
            vld1          <= 1'b0;
            vld2          <= 1'b0;
            addr1         <= '0;
            addr2         <= '0;
            skid_cnt      <= 2'd0;
            skid_addr[0]  <= '0;
            skid_addr[1]  <= '0;
            skid_data[0]  <= '0;
            skid_data[1]  <= '0;
            o_Instruction <= '0;
            o_PC          <= '0;
            o_Valid       <= 1'b0;
        end else begin
            // In IDLE a redirect only repositions the PC.
            if (i_Redirect)
                pc <= i_Redirect_Addr;
            else if (issue)
                pc <= pc + 1'b1;   // wraps naturally

            vld1  <= issue;
            addr1 <= pc;
            vld2  <= vld1 && !flush;
            addr2 <= addr1;

            if (flush) begin
                o_Valid  <= 1'b0;
                skid_cnt <= 2'd0;
            end else begin
                if (out_load) begin
                    if (skid_cnt != 2'd0) begin
                        o_Instruction <= skid_data[0];
                        o_PC          <= skid_addr[0];
                        o_Valid       <= 1'b1;
                    end else if (arrive) begin
                        o_Instruction <= i_Mem_Instruction;
                        o_PC          <= addr2;
                        o_Valid       <= 1'b1;
                    end else begin
                        o_Valid <= 1'b0;
                    end
                end
                if (pop) begin
                    skid_addr[0] <= skid_addr[1];
                    skid_data[0] <= skid_data[1];
                end
                // Placed after the shift so a same-cycle push into entry 0
                // overrides the shifted value.
                if (push) begin
                    skid_addr[skid_wr_idx] <= addr2;
                    skid_data[skid_wr_idx] <= i_Mem_Instruction;
                end
                skid_cnt <= skid_cnt + {1'b0, push} - {1'b0, pop};
            end
        end
    end

`ifdef IFETCH_STATS_EN
    // Statistics survive redirects; only reset clears them.
    always_ff @(posedge clk) begin
        if (!reset) begin
            o_Fetch_Count <= 16'd0;
            o_Stall_Count <= 16'd0;
        end else begin
            if (accept && (o_Fetch_Count != 16'hFFFF))
                o_Fetch_Count <= o_Fetch_Count + 16'd1;
            if (o_Valid && i_Stall && (o_Stall_Count != 16'hFFFF))
                o_Stall_Count <= o_Stall_Count + 16'd1;
        end
    end
`else
    // Statistics counters not built.
`endif

endmodule

// File: doc/instr_fetch_ctrl.md
# instr_fetch_ctrl

Fetch sequencer for the 2-cycle-latency instruction memory (registered ROM plus registered output). Owns the program counter and drives the memory address. Tracks in-flight reads and buffers returning words so a downstream decode stage can stall, or redirect the stream on a branch, without losing or duplicating instructions. Sits between the instruction memory and the decode stage.

## Interface
- ADDR_WIDTH, 7, PC and memory address width
- DATA_WIDTH, 27, instruction width
- START_ADDR, 0, PC value after reset
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-low reset
- i_Start  input  1  pulse: leave IDLE and begin fetching
- i_Stop  input  1  pulse: stop issuing, drain, return to IDLE
- i_Stall  input  1  consumer not accepting this cycle
- i_Redirect  input  1  branch/jump: flush and refetch from i_Redirect_Addr
- i_Redirect_Addr  input  ADDR_WIDTH  redirect target
- o_Mem_Address  output  ADDR_WIDTH  address to instruction memory
- i_Mem_Instruction  input  DATA_WIDTH  memory read data, 2 cycles after address
- o_Instruction  output  DATA_WIDTH  registered instruction to decode
- o_PC  output  ADDR_WIDTH  address of o_Instruction
- o_Valid  output  1  o_Instruction/o_PC valid
- o_Busy  output  1  state != IDLE

## Operation
- Reset (reset==0 at edge): state IDLE, PC=START_ADDR, o_Mem_Address=START_ADDR, o_Instruction=0, o_PC=0, o_Valid=0, in-flight and skid cleared.
- States: IDLE -> RUN on i_Start; RUN -> DRAIN on i_Stop; DRAIN -> IDLE when in-flight==0 and o_Valid==0 and skid empty; i_Start in DRAIN ignored.
- In-flight tracker: 2-stage shift of {valid, addr} matching memory latency; a stage-2 valid marks i_Mem_Instruction as a real word for that addr.
- Buffering: output register (1 slot) + 2-entry skid FIFO, total 3 slots. Arriving words go to the output register if it is empty or being accepted and skid is empty, else to skid, in order.
- Accept: o_Valid && !i_Stall. Output refills same edge from skid head, else from arriving word.
- Issue (RUN only): issue addr=PC and PC<=PC+1 when occ + inflight - accept < 3, where occ = o_Valid + skid count. Guarantees no overflow; no word is ever dropped except by flush.
- PC wraps ADDR_WIDTH-bit: 127 -> 0, no flag.
- o_Mem_Address = PC register; held constant when not issuing.
- Redirect (RUN or DRAIN, any stall state): clears in-flight valids, skid, o_Valid; PC<=i_Redirect_Addr. Has priority over i_Stop, accept and issue in same cycle. In IDLE, i_Redirect loads PC only; i_Start+i_Redirect together start at i_Redirect_Addr.
- i_Stall while o_Valid==0 has no effect; o_Instruction/o_PC held stable while o_Valid && i_Stall.

## Timing
- i_Start sampled at edge 0: address START_ADDR driven cycle 1, memory data cycle 3, o_Valid=1 cycle 4.
- Steady state without stalls: one instruction per cycle, consecutive o_PC.
- Redirect sampled edge N: target driven cycle N+1, o_Valid low cycles N+1..N+3, target valid cycle N+4.
- Stall release: valid data presented the cycle i_Stall drops; back-to-back thereafter, no bubble from skid.
- Reset mid-operation: takes effect at that edge regardless of state; in-flight memory data afterwards ignored.

## Configuration
- IFETCH_STATS_EN defined: adds outputs o_Fetch_Count[15:0] (accepted instructions) and o_Stall_Count[15:0] (cycles with o_Valid && i_Stall); both reset to 0, saturate at 16'hFFFF, not cleared by redirect.
- Undefined: those ports and counters do not exist; all other behaviour identical.

## Test plan
- Reset then i_Start, no stall -> o_Valid first high cycle 4 with o_PC=0, then o_PC 1,2,3... every cycle, data matching ROM.
- Stall held 5 cycles mid-stream at o_PC=10 -> o_PC=10 held, o_Mem_Address frozen, on release o_PC 10,11,12,13 back-to-back, no gaps/duplicates.
- Redirect to 0x40 while stalled with full skid -> o_Valid low 3 cycles, then o_PC=0x40,0x41; no pre-redirect words appear.
- Run past 0x7F -> o_PC 0x7E,0x7F,0x00,0x01.
- i_Stop at o_PC=5 -> issues cease, buffered/in-flight words delivered, then o_Busy=0, o_Valid=0; i_Start resumes from next PC.
- With IFETCH_STATS_EN: 20 accepts, 4 stall cycles -> o_Fetch_Count=20, o_Stall_Count=4; reset -> both 0.
